calc_req_sched: RTL and testbench
=================================

# calc_req_sched

Request scheduler sitting directly upstream of the four-port calculator DUT, and draining its response side. Accepts a single valid/ready stream of two-operand commands and picks a port round-robin. Allocates a free 2-bit tag on that port and drives the calculator's two-cycle request protocol (command + operand 1, then operand 2). Captures every port's responses into per-port buffers and returns them on one valid/ready response stream, freeing the tag on delivery.

## Interface

- CALC_CMD_WIDTH, 4, command field width
- CALC_DATA_WIDTH, 32, operand/result width

- PClk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted on edge where in_valid&in_ready
- in_cmd  in  CALC_CMD_WIDTH  calculator command
- in_op1  in  CALC_DATA_WIDTH  first operand
- in_op2  in  CALC_DATA_WIDTH  second operand
- req_cmd  out  4*CALC_CMD_WIDTH  port N command (slice N-1), to reqN_cmd_in
- req_data  out  4*CALC_DATA_WIDTH  port N data, to reqN_data_in
- req_tag  out  8  port N tag, to reqN_tag_in
- out_resp  in  8  port N response code from out_respN (00 none)
- out_data  in  4*CALC_DATA_WIDTH  port N result from out_dataN
- out_tag  in  8  port N tag from out_tagN
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response on edge where rsp_valid&rsp_ready
- rsp_port  out  2  port index 0..3
- rsp_tag  out  2  tag
- rsp_resp  out  2  response code as returned by DUT
- rsp_data  out  CALC_DATA_WIDTH  result
- err_unexp  out  1  sticky: response seen for a tag not outstanding

## Operation

- Tag state: 4x4 busy bits. A tag is set on issue and cleared when its response is popped on rsp, not when it is received. This bounds each port buffer to 4 entries and makes overflow impossible.
- Issue FSM, states IDLE, OP1, OP2.
  - IDLE: in_ready=1 iff at least one port has a free tag.
  - Port choice: the first port at or after rr_ptr with a free tag. Tag choice: the lowest free index on that port.
- Accept with in_cmd!=0: latch the request, set busy, set rr_ptr=port+1 mod 4, go to OP1.
  - OP1: the chosen port drives cmd=in_cmd, data=op1, tag.
  - OP2: the same port drives cmd=0, data=op2, same tag.
  - Return to IDLE.
- Accept with in_cmd==0: the handshake completes, nothing is driven, no tag is allocated, and the FSM stays in IDLE.
- Ports not being driven present cmd=0, data=0, tag=0.
- Invalid command codes are forwarded unchanged; the DUT's error response is returned normally.
- Capture: each cycle, for every port with out_resp!=00:
  - tag busy → push {resp, tag, data} into that port's 4-entry FIFO.
  - tag not busy → drop and set err_unexp.
  - All four ports may push in the same cycle.
- Drain: a round-robin arbiter over non-empty FIFOs presents the head entry.
  - The output is held stable until it is taken.
  - On pop: clear the busy bit, advance the drain pointer past the granted port.
  - A push and a pop on the same FIFO in the same cycle are both honoured.

## Timing

- Reset (async assert, sync release):
  - All outputs 0; in_ready=0 while Rst=1.
  - Busy bits cleared, FIFOs empty, rr_ptr and drain pointer set to port 0, FSM IDLE, err_unexp cleared.
  - In the first cycle after release, in_ready=1.
- Issue: accept edge E. After E, OP1 values are on the port. After E+1, OP2 values. After E+2, the port returns to zeros and in_ready may be 1 again. Peak rate is 1 request per 3 cycles.
- in_ready is low in OP1 and OP2.
- A tag freed by a pop at edge E is selectable for an accept at E+1 (no same-edge bypass).
- Response capture is registered: out_resp!=00 sampled at edge E gives rsp_valid=1 after E, if the arbiter grants that port.
- When all 16 tags are busy, in_ready=0 until a pop.
- Reset mid-sequence abandons the request; the DUT shares Rst.

## Test plan

- Single add: cmd=1, op1=5, op2=7.
  - Port 0 shows (1,5,tag 0) then (0,7,tag 0).
  - DUT resp 01/data 12 → rsp port0, tag0, resp01, data 12; busy cleared.
- Round-robin: 5 back-to-back requests → issued to ports 0,1,2,3,0, with port 0 using tags 0 then 1.
- Tag exhaustion: 16 requests, no responses → in_ready=0 after the 16th. Pop one response from port 2 tag 3 → the next request goes to port 2, tag 3.
- Simultaneous responses: all 4 ports respond in one cycle, rsp_ready held low 3 cycles then high → 4 responses delivered in consecutive cycles in port order 0,1,2,3 with no loss.
- Error cases:
  - Response on port 1 with an unused tag → dropped, err_unexp=1 and sticky.
  - in_cmd=0 request → accepted, no port activity, no tag consumed.
- Reset asserted during OP1 → all outputs 0 immediately. After release, in_ready=1 and the issue order restarts at port 0, tag 0.

Source files
------------

// File: rtl/calc_req_sched_if.sv
// Bundle of the scheduler's request stream, calculator port buses and response stream.
// The slave modport is the scheduler itself; master is the surrounding environment.
interface calc_req_sched_if #(
   parameter int CALC_CMD_WIDTH  = 4,
   parameter int CALC_DATA_WIDTH = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic [CALC_CMD_WIDTH-1:0]    in_cmd;
   logic [CALC_DATA_WIDTH-1:0]   in_op1;
   logic [CALC_DATA_WIDTH-1:0]   in_op2;
   logic [4*CALC_CMD_WIDTH-1:0]  req_cmd;
   logic [4*CALC_DATA_WIDTH-1:0] req_data;
   logic [7:0]                   req_tag;
   logic [7:0]                   out_resp;
   logic [4*CALC_DATA_WIDTH-1:0] out_data;
   logic [7:0]                   out_tag;
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [1:0]                   rsp_port;
   logic [1:0]                   rsp_tag;
   logic [1:0]                   rsp_resp;
   logic [CALC_DATA_WIDTH-1:0]   rsp_data;
   logic                         err_unexp;

   modport master (
      output in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag, rsp_ready,
      input  in_ready, req_cmd, req_data, req_tag, rsp_valid, rsp_port, rsp_tag, rsp_resp,
             rsp_data, err_unexp
   );

   modport slave (
      input  in_valid, in_cmd, in_op1, in_op2, out_resp, out_data, out_tag, rsp_ready,
      output in_ready, req_cmd, req_data, req_tag, rsp_valid, rsp_port, rsp_tag, rsp_resp,
             rsp_data, err_unexp
   );
endinterface

// File: rtl/calc_req_sched.sv
// Round-robin request scheduler for the four-port calculator: tag allocation, two-cycle
// request issue, per-port response capture FIFOs and a round-robin response drain.
module calc_req_sched #(
   parameter int CALC_CMD_WIDTH  = 4,
   parameter int CALC_DATA_WIDTH = 32
) (
   input logic              PClk,
   input logic              Rst,
   calc_req_sched_if.slave  bus
);
   localparam int CW = CALC_CMD_WIDTH;
   localparam int DW = CALC_DATA_WIDTH;
   localparam int EW = DW + 4;

   typedef enum logic [1:0] {IDLE, OP1, OP2} state_t;

   state_t          state_q;
   logic [1:0]      port_q, rr_q, drain_q, lock_port_q;
   logic            lock_q, in_ready_q, err_q;
   logic [DW-1:0]   op2_q;
   logic [15:0]     busy_q, busy_d;
   logic [4*CW-1:0] req_cmd_q;
   logic [4*DW-1:0] req_data_q;
   logic [7:0]      req_tag_q;
   logic [EW-1:0]   mem_q [4][4];
   logic [1:0]      wp_q [4];
   logic [1:0]      rp_q [4];
   logic [2:0]      cnt_q [4];

   logic [3:0]      port_free, nonempty, push, unexp;
   logic [1:0]      sel_port, sel_tag, cand, arb, gnt;
   logic            accept, issue, gnt_vld, pop;
   logic [EW-1:0]   head;

   always_comb begin
      cand = '0;
      for (int unsigned p = 0; p < 4; p++) begin
         port_free[p] = ~&busy_q[4*p +: 4];
         nonempty[p]  = cnt_q[p] != 3'd0;
      end

      // Descending scan so the last hit is the nearest port at/after the pointer.
      sel_port = rr_q;
      for (int unsigned k = 4; k > 0; k--) begin
         cand = rr_q + 2'(k - 1);
         if (port_free[cand]) sel_port = cand;
      end
      sel_tag = '0;
      for (int unsigned k = 4; k > 0; k--)
         if (!busy_q[{sel_port, 2'(k - 1)}]) sel_tag = 2'(k - 1);

      accept = bus.in_valid && in_ready_q;
      issue  = accept && (bus.in_cmd != '0);

      arb = drain_q;
      for (int unsigned k = 4; k > 0; k--) begin
         cand = drain_q + 2'(k - 1);
         if (nonempty[cand]) arb = cand;
      end
      // A presented entry stays granted until popped, even if a nearer FIFO fills.
      gnt     = lock_q ? lock_port_q : arb;
      gnt_vld = |nonempty;
      head    = mem_q[gnt][rp_q[gnt]];
      pop     = gnt_vld && bus.rsp_ready;

      for (int unsigned p = 0; p < 4; p++) begin
         push[p]  = (bus.out_resp[2*p +: 2] != 2'b00) && busy_q[{2'(p), bus.out_tag[2*p +: 2]}] &&
                    ((cnt_q[p] != 3'd4) || (pop && (gnt == 2'(p))));
         unexp[p] = (bus.out_resp[2*p +: 2] != 2'b00) && !busy_q[{2'(p), bus.out_tag[2*p +: 2]}];
      end

      busy_d = busy_q;
      if (pop)   busy_d[{gnt, head[DW+1:DW]}] = 1'b0;
      if (issue) busy_d[{sel_port, sel_tag}]  = 1'b1;
   end

   always_ff @(posedge PClk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         port_q      <= '0;
         rr_q        <= '0;
         drain_q     <= '0;
         lock_q      <= 1'b0;
         lock_port_q <= '0;
         in_ready_q  <= 1'b0;
         err_q       <= 1'b0;
         op2_q       <= '0;
         busy_q      <= '0;
         req_cmd_q   <= '0;
         req_data_q  <= '0;
         req_tag_q   <= '0;
         for (int unsigned p = 0; p < 4; p++) begin
            wp_q[p]  <= '0;
            rp_q[p]  <= '0;
            cnt_q[p] <= '0;
         end
      end else begin
         busy_q      <= busy_d;
         err_q       <= err_q | (|unexp);
         lock_q      <= gnt_vld && !bus.rsp_ready;
         lock_port_q <= gnt;
         if (pop) drain_q <= gnt + 2'd1;

         for (int unsigned p = 0; p < 4; p++) begin
            if (push[p]) wp_q[p] <= wp_q[p] + 2'd1;
            if (pop && (gnt == 2'(p))) rp_q[p] <= rp_q[p] + 2'd1;
            cnt_q[p] <= cnt_q[p] + {2'b00, push[p]} - {2'b00, pop && (gnt == 2'(p))};
         end

         case (state_q)
            IDLE: if (issue) begin
               state_q                          <= OP1;
               port_q                           <= sel_port;
               rr_q                             <= sel_port + 2'd1;
               op2_q                            <= bus.in_op2;
               req_cmd_q[CW*sel_port +: CW]     <= bus.in_cmd;
               req_data_q[DW*sel_port +: DW]    <= bus.in_op1;
               req_tag_q[2*sel_port +: 2]       <= sel_tag;
            end
            OP1: begin
               state_q                          <= OP2;
               req_cmd_q[CW*port_q +: CW]       <= '0;
               req_data_q[DW*port_q +: DW]      <= op2_q;
            end
            OP2: begin
               state_q    <= IDLE;
               req_cmd_q  <= '0;
               req_data_q <= '0;
               req_tag_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase

         // Ready for the next cycle reflects the post-edge tag state (no same-edge bypass).
         in_ready_q <= ((state_q == OP2) || ((state_q == IDLE) && !issue)) && !(&busy_d);
      end
   end

   always_ff @(posedge PClk) begin
      for (int unsigned p = 0; p < 4; p++)
         if (push[p])
            mem_q[p][wp_q[p]] <= {bus.out_resp[2*p +: 2], bus.out_tag[2*p +: 2], bus.out_data[DW*p +: DW]};
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.req_cmd   = req_cmd_q;
   assign bus.req_data  = req_data_q;
   assign bus.req_tag   = req_tag_q;
   assign bus.err_unexp = err_q;
   assign bus.rsp_valid = gnt_vld;
   assign bus.rsp_port  = gnt_vld ? gnt : '0;
   assign bus.rsp_resp  = gnt_vld ? head[DW+3:DW+2] : '0;
   assign bus.rsp_tag   = gnt_vld ? head[DW+1:DW] : '0;
   assign bus.rsp_data  = gnt_vld ? head[DW-1:0] : '0;
endmodule

// File: tb/tb_calc_req_sched.sv
// Self-checking bench for calc_req_sched: directed scenarios plus randomized traffic,
// checked against a queue-based model of tag ownership and response delivery.
module tb_calc_req_sched;
   logic PClk = 1'b0;
   logic Rst  = 1'b1;
   always #5 PClk = ~PClk;

   calc_req_sched_if #(.CALC_CMD_WIDTH(4), .CALC_DATA_WIDTH(32)) bus ();
   calc_req_sched #(.CALC_CMD_WIDTH(4), .CALC_DATA_WIDTH(32)) dut (.PClk(PClk), .Rst(Rst), .bus(bus));

   typedef struct packed {logic [1:0] resp; logic [1:0] tag; logic [31:0] data;} ent_t;

   int   nvec = 0;
   int   nerr = 0;
   bit   m_busy [4][4];
   bit   m_done [4][4];
   ent_t m_q [4][$];
   int   m_rr, m_drain;
   int   m_hold = -1;
   bit   m_err;

   function automatic int arb_port();
      int r;
      r = -1;
      for (int k = 3; k >= 0; k--)
         if (m_q[(m_drain + k) % 4].size() > 0) r = (m_drain + k) % 4;
      return r;
   endfunction

   function automatic int free_count();
      int n;
      n = 0;
      for (int p = 0; p < 4; p++)
         for (int t = 0; t < 4; t++)
            if (!m_busy[p][t]) n++;
      return n;
   endfunction

   function automatic void pick(output int p, output int t);
      int q;
      p = -1;
      t = -1;
      for (int k = 0; k < 4; k++) begin
         q = (m_rr + k) % 4;
         if (p < 0)
            for (int j = 0; j < 4; j++)
               if (t < 0 && !m_busy[q][j]) begin p = q; t = j; end
      end
   endfunction

   // An entry shown but not taken on an edge stays presented until it is taken.
   always @(posedge PClk) begin
      if (Rst || bus.rsp_ready) m_hold = -1;
      else if (m_hold < 0) m_hold = arb_port();
   end

   task automatic model_reset();
      for (int p = 0; p < 4; p++) begin
         m_q[p].delete();
         for (int t = 0; t < 4; t++) begin m_busy[p][t] = 0; m_done[p][t] = 0; end
      end
      m_rr = 0; m_drain = 0; m_err = 0;
   endtask

   // Called at a falling edge; asserts reset immediately.
   task automatic apply_reset();
      Rst = 1'b1;
      bus.in_valid = 0; bus.in_cmd = '0; bus.in_op1 = '0; bus.in_op2 = '0;
      bus.out_resp = '0; bus.out_tag = '0; bus.out_data = '0; bus.rsp_ready = 0;
      #1;
      nvec++;
      if ({bus.in_ready, bus.req_cmd, bus.req_data, bus.req_tag, bus.rsp_valid, bus.rsp_port,
           bus.rsp_tag, bus.rsp_resp, bus.rsp_data, bus.err_unexp} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: in_ready=%b req_cmd=%h req_tag=%h rsp_valid=%b err=%b, required all 0",
                  bus.in_ready, bus.req_cmd, bus.req_tag, bus.rsp_valid, bus.err_unexp);
      end
      model_reset();
      @(negedge PClk); @(negedge PClk);
      Rst = 1'b0;
      @(negedge PClk);
      nvec++;
      if (bus.in_ready !== 1'b1) begin
         nerr++; $display("FAIL reset_release_ready: in_ready=%b required 1", bus.in_ready);
      end
   endtask

   task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      int p, t, n;
      logic [15:0] ec; logic [127:0] ed; logic [7:0] et;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin @(negedge PClk); n++; end
      nvec++;
      if (bus.in_ready !== 1'b1) begin
         nerr++; $display("FAIL issue_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
         return;
      end
      pick(p, t);
      bus.in_valid = 1; bus.in_cmd = cmd; bus.in_op1 = a; bus.in_op2 = b;
      @(negedge PClk);
      bus.in_valid = 0;
      if (cmd == 4'd0) begin
         nvec++;
         if ({bus.req_cmd, bus.req_data, bus.req_tag} !== '0 || bus.in_ready !== 1'b1) begin
            nerr++; $display("FAIL cmd0_idle: req_cmd=%h req_tag=%h in_ready=%b, required 0/0/1",
                             bus.req_cmd, bus.req_tag, bus.in_ready);
         end
         return;
      end
      m_busy[p][t] = 1; m_rr = (p + 1) % 4;
      ec = '0; ed = '0; et = '0;
      ec[4*p +: 4] = cmd; ed[32*p +: 32] = a; et[2*p +: 2] = 2'(t);
      nvec++;
      if ({bus.req_cmd, bus.req_data, bus.req_tag, bus.in_ready} !== {ec, ed, et, 1'b0}) begin
         nerr++; $display("FAIL issue_op1: cmd=%h tag=%h data=%h rdy=%b, required cmd=%h tag=%h data=%h rdy=0",
                          bus.req_cmd, bus.req_tag, bus.req_data, bus.in_ready, ec, et, ed);
      end
      @(negedge PClk);
      ec[4*p +: 4] = 4'd0; ed[32*p +: 32] = b;
      nvec++;
      if ({bus.req_cmd, bus.req_data, bus.req_tag, bus.in_ready} !== {ec, ed, et, 1'b0}) begin
         nerr++; $display("FAIL issue_op2: cmd=%h tag=%h data=%h rdy=%b, required cmd=%h tag=%h data=%h rdy=0",
                          bus.req_cmd, bus.req_tag, bus.req_data, bus.in_ready, ec, et, ed);
      end
      @(negedge PClk);
      nvec++;
      if ({bus.req_cmd, bus.req_data, bus.req_tag} !== '0 || bus.in_ready !== (free_count() > 0)) begin
         nerr++; $display("FAIL issue_done: req_cmd=%h req_tag=%h in_ready=%b, required 0/0/%b",
                          bus.req_cmd, bus.req_tag, bus.in_ready, free_count() > 0);
      end
   endtask

   task automatic respond(input logic [7:0] rs, input logic [7:0] tg, input logic [127:0] dt);
      bit hit [4];
      bus.out_resp = rs; bus.out_tag = tg; bus.out_data = dt;
      for (int p = 0; p < 4; p++) begin
         hit[p] = 0;
         if (rs[2*p +: 2] != 2'b00) begin
            if (m_busy[p][tg[2*p +: 2]]) hit[p] = 1;
            else m_err = 1;
         end
      end
      @(negedge PClk);
      bus.out_resp = '0; bus.out_tag = '0; bus.out_data = '0;
      for (int p = 0; p < 4; p++)
         if (hit[p]) begin
            m_q[p].push_back('{resp: rs[2*p +: 2], tag: tg[2*p +: 2], data: dt[32*p +: 32]});
            m_done[p][tg[2*p +: 2]] = 1;
         end
      nvec++;
      if (bus.err_unexp !== m_err) begin
         nerr++; $display("FAIL err_unexp: got %b required %b", bus.err_unexp, m_err);
      end
   endtask

   task automatic drain_one();
      int p; ent_t e;
      p = (m_hold >= 0) ? m_hold : arb_port();
      nvec++;
      if (p < 0) begin
         if (bus.rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL drain_empty: rsp_valid=%b required 0", bus.rsp_valid);
         end
         @(negedge PClk);
         return;
      end
      e = m_q[p][0];
      if ({bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_resp, bus.rsp_data} !==
          {1'b1, 2'(p), e.tag, e.resp, e.data}) begin
         nerr++; $display("FAIL drain: v=%b port=%0d tag=%0d resp=%0d data=%h, required 1 port=%0d tag=%0d resp=%0d data=%h",
                          bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_resp, bus.rsp_data, p, e.tag, e.resp, e.data);
      end
      bus.rsp_ready = 1;
      @(negedge PClk);
      bus.rsp_ready = 0;
      void'(m_q[p].pop_front());
      m_busy[p][e.tag] = 0; m_done[p][e.tag] = 0;
      m_drain = (p + 1) % 4;
   endtask

   task automatic test_reset();
      apply_reset();
      nvec++;
      if ({bus.rsp_valid, bus.err_unexp, bus.req_cmd} !== '0) begin
         nerr++; $display("FAIL reset_idle: rsp_valid=%b err=%b req_cmd=%h, required 0", bus.rsp_valid, bus.err_unexp, bus.req_cmd);
      end
   endtask

   task automatic test_single_add();
      apply_reset();
      issue(4'd1, 32'd5, 32'd7);
      respond(8'h01, 8'h00, {96'd0, 32'd12});
      nvec++;
      if ({bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_resp, bus.rsp_data} !== {1'b1, 2'd0, 2'd0, 2'b01, 32'd12}) begin
         nerr++; $display("FAIL single_add_rsp: v=%b port=%0d tag=%0d resp=%0d data=%0d, required 1/0/0/1/12",
                          bus.rsp_valid, bus.rsp_port, bus.rsp_tag, bus.rsp_resp, bus.rsp_data);
      end
      drain_one();
      // Tag 0 is free again, so a repeat response must be flagged as unexpected.
      respond(8'h01, 8'h00, {96'd0, 32'd12});
      nvec++;
      if (bus.err_unexp !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL single_add_freed: err=%b rsp_valid=%b, required 1/0", bus.err_unexp, bus.rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      repeat (5) issue(4'($urandom_range(1, 15)), $urandom, $urandom);
   endtask

   task automatic test_exhaustion();
      apply_reset();
      repeat (16) issue(4'($urandom_range(1, 15)), $urandom, $urandom);
      nvec++;
      if (bus.in_ready !== 1'b0) begin
         nerr++; $display("FAIL exhaust_ready: in_ready=%b required 0", bus.in_ready);
      end
      respond(8'h10, 8'h30, {32'd0, 32'hCAFE0023, 64'd0});
      drain_one();
      nvec++;
      if (bus.in_ready !== 1'b1) begin
         nerr++; $display("FAIL exhaust_freed_ready: in_ready=%b required 1", bus.in_ready);
      end
      issue(4'd2, $urandom, $urandom);
   endtask

   task automatic test_simultaneous();
      logic [7:0] rs;
      apply_reset();
      repeat (4) issue(4'($urandom_range(1, 15)), $urandom, $urandom);
      rs = {2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3))};
      respond(rs, 8'h00, {$urandom, $urandom, $urandom, $urandom});
      for (int c = 0; c < 3; c++) begin
         nvec++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_port !== 2'd0) begin
            nerr++; $display("FAIL simul_hold: cycle %0d rsp_valid=%b port=%0d, required 1/0", c, bus.rsp_valid, bus.rsp_port);
         end
         @(negedge PClk);
      end
      repeat (4) drain_one();
      nvec++;
      if (bus.rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL simul_empty: rsp_valid=%b required 0", bus.rsp_valid);
      end
   endtask

   task automatic test_errors();
      apply_reset();
      issue(4'd2, $urandom, $urandom);
      respond(8'h08, 8'h08, {$urandom, $urandom, $urandom, $urandom});
      repeat (3) @(negedge PClk);
      nvec++;
      if (bus.err_unexp !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         nerr++; $display("FAIL err_sticky: err=%b rsp_valid=%b, required 1/0", bus.err_unexp, bus.rsp_valid);
      end
      issue(4'd0, $urandom, $urandom);
      issue(4'd3, $urandom, $urandom);
   endtask

   task automatic test_random();
      int r, n, c;
      int cand [4];
      logic [7:0] rs, tg;
      apply_reset();
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4 && free_count() > 0) begin
            issue(4'($urandom_range(0, 15)), $urandom, $urandom);
         end else if (r < 7) begin
            rs = '0; tg = '0;
            for (int p = 0; p < 4; p++) begin
               if ($urandom_range(0, 1) == 0) continue;
               n = 0;
               for (int t = 0; t < 4; t++) if (m_busy[p][t] && !m_done[p][t]) begin cand[n] = t; n++; end
               if (n > 0) begin
                  c = cand[$urandom_range(0, n - 1)];
                  rs[2*p +: 2] = 2'($urandom_range(1, 3)); tg[2*p +: 2] = 2'(c);
               end else if ($urandom_range(0, 7) == 0) begin
                  for (int t = 0; t < 4; t++) if (!m_busy[p][t]) tg[2*p +: 2] = 2'(t);
                  if (!m_busy[p][tg[2*p +: 2]]) rs[2*p +: 2] = 2'b11;
               end
            end
            if (rs != '0) respond(rs, tg, {$urandom, $urandom, $urandom, $urandom});
         end else begin
            drain_one();
         end
      end
      for (int k = 0; k < 20 && arb_port() >= 0; k++) drain_one();
      drain_one();
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset();
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 10) begin @(negedge PClk); n++; end
      bus.in_valid = 1; bus.in_cmd = 4'd5; bus.in_op1 = 32'h1234_5678; bus.in_op2 = 32'h9ABC_DEF0;
      @(negedge PClk);
      bus.in_valid = 0;
      nvec++;
      if (bus.req_cmd !== 16'h0005 || bus.req_data[31:0] !== 32'h1234_5678) begin
         nerr++; $display("FAIL reset_mid_op1: req_cmd=%h data0=%h, required 0005/12345678", bus.req_cmd, bus.req_data[31:0]);
      end
      apply_reset();
      issue(4'd6, $urandom, $urandom);
   endtask

   initial begin
      @(negedge PClk);
      test_reset();
      test_single_add();
      test_round_robin();
      test_exhaustion();
      test_simultaneous();
      test_errors();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
